// File: rtl/mult_rr_arbiter.sv
// Round-robin front end sharing one pipelined 12x12 multiplier among NREQ
// requesters; products return on one ID-tagged bus exactly two cycles after grant.

module multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] a_i,
   input  logic [11:0] b_i,
   output logic [23:0] p_o
);

   logic [11:0] a_q;
   logic [11:0] b_q;
   logic [23:0] p_q;

   // Operand capture stage followed by product stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= 12'd0;
         b_q <= 12'd0;
         p_q <= 24'd0;
      end else begin
         a_q <= a_i;
         b_q <= b_i;
         p_q <= 24'(a_q) * 24'(b_q);
      end
   end

   assign p_o = p_q;

endmodule

module mult_rr_arbiter #(
   parameter  int NREQ = 4,
   parameter  int CNTW = 16,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [12*NREQ-1:0]   req_a,
   input  logic [12*NREQ-1:0]   req_b,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [23:0]          rsp_c,
   output logic                 busy,
   output logic [CNTW-1:0]      op_cnt
);

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic            v1_q, v2_q;
   logic [IDW-1:0]  id1_q, id2_q;
   logic            busy_q;
   logic [CNTW-1:0] op_cnt_q, op_cnt_d;

   logic [NREQ-1:0] grant_s;
   logic [IDW-1:0]  grant_id_s;
   logic            found_s;
   logic            xfer_s;
   logic [IDW:0]    sum_s;
   logic [IDW-1:0]  idx_s;
   logic [11:0]     mul_a_s, mul_b_s;
   logic [11:0]     a_arr_s [NREQ];
   logic [11:0]     b_arr_s [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr_s[g] = req_a[12*g +: 12];
      assign b_arr_s[g] = req_b[12*g +: 12];
   end

   // Grant search starting at ptr, wrapping modulo NREQ; first valid wins.
   always_comb begin
      grant_s    = '0;
      grant_id_s = '0;
      found_s    = 1'b0;
      sum_s      = '0;
      idx_s      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
         sum_s = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
         idx_s = sum_s[IDW-1:0];
         if (!found_s && en && req_valid[idx_s]) begin
            found_s        = 1'b1;
            grant_s[idx_s] = 1'b1;
            grant_id_s     = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign xfer_s    = |grant_s;
   // Ready is masked while reset is asserted so no requester sees a phantom grant.
   assign req_ready = rst ? grant_s : '0;

   // Operand mux, pointer advance and counter next-state.
   always_comb begin
      mul_a_s  = 12'd0;
      mul_b_s  = 12'd0;
      ptr_d    = ptr_q;
      op_cnt_d = op_cnt_q;
      if (xfer_s) begin
         mul_a_s  = a_arr_s[grant_id_s];
         mul_b_s  = b_arr_s[grant_id_s];
         ptr_d    = (grant_id_s == IDW'(NREQ-1)) ? '0 : grant_id_s + IDW'(1);
         op_cnt_d = op_cnt_q + CNTW'(1);
      end else begin
         mul_a_s  = 12'd0;
         mul_b_s  = 12'd0;
         ptr_d    = ptr_q;
         op_cnt_d = op_cnt_q;
      end
   end

   // Pointer, tag pipeline, busy flag and operation counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q    <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         id1_q    <= '0;
         id2_q    <= '0;
         busy_q   <= 1'b0;
         op_cnt_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         v1_q     <= xfer_s;
         id1_q    <= grant_id_s;
         v2_q     <= v1_q;
         id2_q    <= id1_q;
         busy_q   <= xfer_s | v1_q;
         op_cnt_q <= op_cnt_d;
      end
   end

   multiplier u_mult (
      .clk   (clk),
      .rst_n (rst),
      .a_i   (mul_a_s),
      .b_i   (mul_b_s),
      .p_o   (rsp_c)
   );

   assign rsp_valid = v2_q;
   assign rsp_id    = id2_q;
   assign busy      = busy_q;
   assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed self-checking bench for mult_rr_arbiter (NREQ=4); each task drives a
// scenario and compares against hand-computed grants, IDs and products.

module tb_mult_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [47:0] req_a;
   logic [47:0] req_b;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [23:0] rsp_c;
   logic        busy;
   logic [15:0] op_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [23:0] exp_c [4];

   always #5 clk = ~clk;

   mult_rr_arbiter #(.NREQ(4), .CNTW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_c     (rsp_c),
      .busy      (busy),
      .op_cnt    (op_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      tick();
      req_valid = 4'b0000;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      en = 1'b1;
      req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (op_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_op_cnt: got %0d want 0", op_cnt); end
      n_cmp++; if (rsp_c !== 24'd0) begin n_bad++; $display("FAIL reset_rsp_c: got %h want 0", rsp_c); end
      tick();
      settle();
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready_edge: got %b want %b", req_ready, 4'b0000); end
      n_cmp++; if (op_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_op_cnt_edge: got %0d want 0", op_cnt); end
      req_valid = 4'b0000;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_single();
      req_valid = 4'b0100;
      req_a[35:24] = 12'hFFF;
      req_b[35:24] = 12'hFFF;
      settle();
      n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want %b", req_ready, 4'b0100); end
      tick();
      req_valid = 4'b0000;
      settle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: got %b want 1", busy); end
      tick();
      settle();
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
      n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
      n_cmp++; if (rsp_c !== 24'hFFE001) begin n_bad++; $display("FAIL single_rsp_c: got %h want ffe001", rsp_c); end
      n_cmp++; if (op_cnt !== 16'd1) begin n_bad++; $display("FAIL single_op_cnt: got %0d want 1", op_cnt); end
      tick();
      settle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp_pulse: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", busy); end
   endtask

   // Entered with ptr=3 (last grant went to requester 2).
   task automatic test_pointer_skip();
      req_a[11:0]  = 12'h012; req_b[11:0]  = 12'h034;
      req_a[23:12] = 12'h0FF; req_b[23:12] = 12'h0FF;
      tick();
      req_valid = 4'b0011;
      settle();
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL skip_grant0: got %b want %b", req_ready, 4'b0001); end
      tick();
      req_valid = 4'b0010;
      settle();
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL skip_grant1: got %b want %b", req_ready, 4'b0010); end
      tick();
      req_valid = 4'b0000;
      settle();
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL skip_none: got %b want %b", req_ready, 4'b0000); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== 24'h0003A8) begin n_bad++; $display("FAIL skip_rsp0: got v=%b id=%0d c=%h want v=1 id=0 c=0003a8", rsp_valid, rsp_id, rsp_c); end
      tick();
      req_valid = 4'b1011;
      settle();
      n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL skip_ptr2: got %b want %b", req_ready, 4'b1000); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 24'h00FE01) begin n_bad++; $display("FAIL skip_rsp1: got v=%b id=%0d c=%h want v=1 id=1 c=00fe01", rsp_valid, rsp_id, rsp_c); end
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
      tick();
   endtask

   task automatic test_fairness();
      req_a[11:0]  = 12'h012; req_b[11:0]  = 12'h034;
      req_a[23:12] = 12'h0FF; req_b[23:12] = 12'h0FF;
      req_a[35:24] = 12'h800; req_b[35:24] = 12'h002;
      req_a[47:36] = 12'h123; req_b[47:36] = 12'h010;
      for (int c = 0; c < 10; c++) begin
         tick();
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         en = 1'b1;
         settle();
         if (c < 8) begin
            n_cmp++; if (req_ready !== (4'b0001 << (c % 4))) begin n_bad++; $display("FAIL fair_grant[%0d]: got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
         end
         if (c >= 2) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_c !== exp_c[(c - 2) % 4]) begin
               n_bad++; $display("FAIL fair_rsp[%0d]: got v=%b id=%0d c=%h want v=1 id=%0d c=%h", c, rsp_valid, rsp_id, rsp_c, (c - 2) % 4, exp_c[(c - 2) % 4]);
            end
         end
         if (c == 9) begin
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fair_busy_last: got %b want 1", busy); end
         end
      end
      tick();
      settle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fair_drain_rsp: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fair_busy_fall: got %b want 0", busy); end
      n_cmp++; if (op_cnt !== 16'd8) begin n_bad++; $display("FAIL fair_op_cnt: got %0d want 8", op_cnt); end
   endtask

   // Entered with ptr=0 and fairness operands still applied.
   task automatic test_en_gating();
      tick();
      en = 1'b1;
      req_valid = 4'b1111;
      settle();
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL en_grant0: got %b want %b", req_ready, 4'b0001); end
      tick();
      settle();
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL en_grant1: got %b want %b", req_ready, 4'b0010); end
      tick();
      en = 1'b0;
      settle();
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL en_block0: got %b want %b", req_ready, 4'b0000); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== 24'h0003A8) begin n_bad++; $display("FAIL en_rsp0: got v=%b id=%0d c=%h want v=1 id=0 c=0003a8", rsp_valid, rsp_id, rsp_c); end
      tick();
      settle();
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL en_block1: got %b want %b", req_ready, 4'b0000); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 24'h00FE01) begin n_bad++; $display("FAIL en_rsp1: got v=%b id=%0d c=%h want v=1 id=1 c=00fe01", rsp_valid, rsp_id, rsp_c); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL en_busy_hold: got %b want 1", busy); end
      tick();
      settle();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL en_rsp_done: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy_fall: got %b want 0", busy); end
      tick();
      req_valid = 4'b0000;
      en = 1'b1;
   endtask

   // Entered with ptr=2.
   task automatic test_reset_mid();
      tick();
      req_valid = 4'b1111;
      settle();
      n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL rmid_grant2: got %b want %b", req_ready, 4'b0100); end
      tick();
      settle();
      n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rmid_grant3: got %b want %b", req_ready, 4'b1000); end
      tick();
      req_valid = 4'b0000;
      settle();
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_rsp: got %b want 1", rsp_valid); end
      rst = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rsp_clear: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_clear: got %b want 0", busy); end
      n_cmp++; if (op_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_cnt_clear: got %0d want 0", op_cnt); end
      n_cmp++; if (rsp_c !== 24'd0) begin n_bad++; $display("FAIL rmid_c_clear: got %h want 0", rsp_c); end
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         settle();
         n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_rsp[%0d]: got %b want 0", c, rsp_valid); end
      end
      tick();
      req_valid = 4'b1111;
      settle();
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_restart: got %b want %b", req_ready, 4'b0001); end
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
      tick();
   endtask

   // Entered with ptr=1.
   task automatic test_boundaries();
      tick();
      req_a[23:12] = 12'h000; req_b[23:12] = 12'hABC;
      req_a[35:24] = 12'h001; req_b[35:24] = 12'h800;
      req_valid = 4'b0010;
      settle();
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bnd_grant1: got %b want %b", req_ready, 4'b0010); end
      tick();
      req_valid = 4'b0100;
      settle();
      n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bnd_grant2: got %b want %b", req_ready, 4'b0100); end
      tick();
      req_valid = 4'b0000;
      settle();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 24'h000000) begin n_bad++; $display("FAIL bnd_zero: got v=%b id=%0d c=%h want v=1 id=1 c=000000", rsp_valid, rsp_id, rsp_c); end
      tick();
      settle();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_c !== 24'h000800) begin n_bad++; $display("FAIL bnd_one: got v=%b id=%0d c=%h want v=1 id=2 c=000800", rsp_valid, rsp_id, rsp_c); end
      tick();
      settle();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bnd_busy_fall: got %b want 0", busy); end
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      en = 1'b1;
      req_valid = 4'b0001;
      settle();
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_grant: got %b want %b", req_ready, 4'b0001); end
      repeat (65535) tick();
      settle();
      n_cmp++; if (op_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_max: got %h want ffff", op_cnt); end
      tick();
      req_valid = 4'b0000;
      settle();
      n_cmp++; if (op_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_zero: got %h want 0000", op_cnt); end
      tick();
      tick();
      settle();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrap_busy_fall: got %b want 0", busy); end
   endtask

   initial begin
      exp_c[0] = 24'h0003A8;
      exp_c[1] = 24'h00FE01;
      exp_c[2] = 24'h001000;
      exp_c[3] = 24'h001230;
      rst       = 1'b0;
      en        = 1'b0;
      req_valid = 4'b0000;
      req_a     = 48'd0;
      req_b     = 48'd0;
      test_reset();
      test_single();
      test_pointer_skip();
      do_reset();
      test_fairness();
      test_en_gating();
      test_reset_mid();
      test_boundaries();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
